// File: rtl/ram_ctrl.sv
// ram_ctrl: single-command request/response front-end for a single-port
// synchronous RAM. One command is accepted at a time. The controller drives
// the RAM strobe for one cycle and captures the RAM's one-cycle completion
// pulse. The result is then returned on a valid/ready response channel.
// A watchdog turns a missing completion into an error response.
module ram_ctrl #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TO_WIDTH       = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_we,
    output logic                  rsp_err,
    output logic                  mem_wr_en,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic                  busy,
    output logic                  timeout_flag
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Last WAIT-cycle count before the access is abandoned.
    localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                  state_q,        state_d;
    logic [TO_WIDTH-1:0]     cnt_q,          cnt_d;
    logic                    mem_wr_en_q,    mem_wr_en_d;
    logic                    mem_rd_en_q,    mem_rd_en_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q,     mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q,    mem_wdata_d;
    logic                    rsp_valid_q,    rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q,    rsp_rdata_d;
    logic                    rsp_we_q,       rsp_we_d;
    logic                    rsp_err_q,      rsp_err_d;
    logic                    timeout_flag_q, timeout_flag_d;

    // Only the handshake-ready and busy indications decode the state directly.
    // req_ready is also masked while reset is asserted.
    assign req_ready    = rst_n & (state_q == IDLE);
    assign busy         = (state_q != IDLE);

    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign rsp_we       = rsp_we_q;
    assign rsp_err      = rsp_err_q;
    assign mem_wr_en    = mem_wr_en_q;
    assign mem_rd_en    = mem_rd_en_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign timeout_flag = timeout_flag_q;

    // Next-state and registered-output computation for the command FSM.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        mem_wr_en_d    = mem_wr_en_q;
        mem_rd_en_d    = mem_rd_en_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_rdata_d    = rsp_rdata_q;
        rsp_we_d       = rsp_we_q;
        rsp_err_d      = rsp_err_q;
        timeout_flag_d = timeout_flag_q;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    mem_addr_d  = req_addr;
                    mem_wdata_d = req_wdata;
                    rsp_we_d    = req_we;
                    mem_wr_en_d = req_we;
                    mem_rd_en_d = ~req_we;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                // The strobe lives for exactly this cycle.
                mem_wr_en_d = 1'b0;
                mem_rd_en_d = 1'b0;
                cnt_d       = '0;
                state_d     = WAIT;
            end
            WAIT: begin
                if (mem_ready) begin
                    rsp_rdata_d = rsp_we_q ? '0 : mem_rdata;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (cnt_q == TO_LAST) begin
                    rsp_rdata_d    = '0;
                    rsp_err_d      = 1'b1;
                    timeout_flag_d = 1'b1;
                    rsp_valid_d    = 1'b1;
                    state_d        = RESP;
                end else begin
                    cnt_d = cnt_q + TO_WIDTH'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            mem_wr_en_q    <= 1'b0;
            mem_rd_en_q    <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_rdata_q    <= '0;
            rsp_we_q       <= 1'b0;
            rsp_err_q      <= 1'b0;
            timeout_flag_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            mem_wr_en_q    <= mem_wr_en_d;
            mem_rd_en_q    <= mem_rd_en_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_rdata_q    <= rsp_rdata_d;
            rsp_we_q       <= rsp_we_d;
            rsp_err_q      <= rsp_err_d;
            timeout_flag_q <= timeout_flag_d;
        end
    end

endmodule

// File: tb/tb_ram_ctrl.sv
// tb_ram_ctrl: directed and randomized bench for ram_ctrl with a simple
// synchronous RAM attached. Expected read data comes from an
// address->data map maintained from the commands the bench issues.
module tb_ram_ctrl;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_we;
    logic          rsp_err;
    logic          mem_wr_en;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ready = 1'b0;
    logic          busy;
    logic          timeout_flag;

    logic          ram_ready_en = 1'b1;
    logic [DW-1:0] ram [256] = '{default: 8'h00};

    logic [DW-1:0] exp_mem [logic [AW-1:0]];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    ram_ctrl #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO),
        .TO_WIDTH      (5)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_we       (rsp_we),
        .rsp_err      (rsp_err),
        .mem_wr_en    (mem_wr_en),
        .mem_rd_en    (mem_rd_en),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .busy         (busy),
        .timeout_flag (timeout_flag)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM: completion pulse the cycle after a strobe.
    always @(posedge clk) begin
        if (mem_wr_en) ram[mem_addr] <= mem_wdata;
        if (mem_rd_en) mem_rdata <= ram[mem_addr];
        mem_ready <= (mem_wr_en | mem_rd_en) & ram_ready_en;
    end

    // Absolute time bound on the whole run.
    initial begin
        #400000;
        $display("FAIL global_timeout: observed no end of test, expected completion");
        $fatal(1, "simulation time limit reached");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_checks++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, want);
        end
    endtask

    function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
        if (exp_mem.exists(a)) return exp_mem[a];
        return '0;
    endfunction

    task automatic check_zero_outputs(input string pfx);
        check({pfx, "_rsp_valid"},    32'(rsp_valid),    0);
        check({pfx, "_rsp_rdata"},    32'(rsp_rdata),    0);
        check({pfx, "_rsp_we"},       32'(rsp_we),       0);
        check({pfx, "_rsp_err"},      32'(rsp_err),      0);
        check({pfx, "_mem_wr_en"},    32'(mem_wr_en),    0);
        check({pfx, "_mem_rd_en"},    32'(mem_rd_en),    0);
        check({pfx, "_mem_addr"},     32'(mem_addr),     0);
        check({pfx, "_mem_wdata"},    32'(mem_wdata),    0);
        check({pfx, "_busy"},         32'(busy),         0);
        check({pfx, "_timeout_flag"}, 32'(timeout_flag), 0);
        check({pfx, "_req_ready"},    32'(req_ready),    0);
    endtask

    // Issue one command, hold the response for 'stall' cycles, then accept it.
    task automatic do_cmd(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                          input int stall, output logic [DW-1:0] rd, output logic er,
                          output logic wecho, output int lat, output int strobes);
        int n;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_valid = 1'b1;
        rsp_ready = 1'b0;
        n = 0;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        check("req_ready_before_accept", 32'(req_ready), 1);
        tick();
        req_valid = 1'b0;
        lat = 1;
        strobes = 0;
        check("strobe_wr_type", 32'(mem_wr_en), 32'(we));
        check("strobe_rd_type", 32'(mem_rd_en), 32'(!we));
        while (!rsp_valid && lat < 60) begin
            if (mem_wr_en || mem_rd_en) strobes++;
            tick();
            lat++;
        end
        check("rsp_valid_seen", 32'(rsp_valid), 1);
        rd    = rsp_rdata;
        er    = rsp_err;
        wecho = rsp_we;
        for (int s = 0; s < stall; s++) begin
            check("hold_rsp_valid", 32'(rsp_valid), 1);
            check("hold_rsp_rdata", 32'(rsp_rdata), 32'(rd));
            check("hold_rsp_err",   32'(rsp_err),   32'(er));
            check("hold_rsp_we",    32'(rsp_we),    32'(wecho));
            check("hold_req_ready", 32'(req_ready), 0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        check("idle_after_rsp_busy",  32'(busy),      0);
        check("idle_after_rsp_valid", 32'(rsp_valid), 0);
    endtask

    initial begin
        logic [DW-1:0] rd;
        logic          er;
        logic          wecho;
        int            lat;
        int            strobes;
        int            acc [4];
        int            idx;
        int            n;
        int            seen;
        logic          rw;
        logic [AW-1:0] ra;
        logic [DW-1:0] rdat;

        // Reset
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;
        tick();
        tick();
        check_zero_outputs("reset");
        rst_n = 1'b1;
        #1;
        check("req_ready_after_reset", 32'(req_ready), 1);
        tick();

        // Write 0xA5 to 0x3C, then read it back
        do_cmd(1'b1, 8'h3C, 8'hA5, 0, rd, er, wecho, lat, strobes);
        exp_mem[8'h3C] = 8'hA5;
        check("wr_rsp_we",    32'(wecho), 1);
        check("wr_rsp_rdata", 32'(rd),    0);
        check("wr_rsp_err",   32'(er),    0);
        check("wr_latency",   32'(lat),   3);
        check("wr_strobe_cycles", 32'(strobes), 1);
        check("addr_held",  32'(mem_addr),  32'h3C);
        check("wdata_held", 32'(mem_wdata), 32'hA5);

        do_cmd(1'b0, 8'h3C, 8'h00, 0, rd, er, wecho, lat, strobes);
        check("rd_rsp_we",    32'(wecho), 0);
        check("rd_rsp_rdata", 32'(rd),    32'(model_rd(8'h3C)));
        check("rd_rsp_err",   32'(er),    0);
        check("rd_latency",   32'(lat),   3);
        check("rd_strobe_cycles", 32'(strobes), 1);

        // Read of a never-written location
        do_cmd(1'b0, 8'h10, 8'h00, 0, rd, er, wecho, lat, strobes);
        check("rd_unwritten_rdata", 32'(rd), 32'(model_rd(8'h10)));
        check("rd_unwritten_err",   32'(er), 0);

        // Response held with rsp_ready low for 5 cycles
        do_cmd(1'b0, 8'h3C, 8'h00, 5, rd, er, wecho, lat, strobes);
        check("stall_rdata", 32'(rd), 32'hA5);

        // Timeout when the RAM never completes
        ram_ready_en = 1'b0;
        do_cmd(1'b0, 8'h20, 8'h00, 0, rd, er, wecho, lat, strobes);
        check("to_rsp_err",   32'(er),  1);
        check("to_rsp_rdata", 32'(rd),  0);
        check("to_latency",   32'(lat), 32'(TO + 2));
        check("to_flag_set",  32'(timeout_flag), 1);
        ram_ready_en = 1'b1;
        do_cmd(1'b0, 8'h3C, 8'h00, 0, rd, er, wecho, lat, strobes);
        check("after_to_rdata", 32'(rd), 32'hA5);
        check("after_to_err",   32'(er), 0);
        check("to_flag_sticky", 32'(timeout_flag), 1);

        // Four back-to-back writes with req_valid held high
        rsp_ready = 1'b1;
        req_we    = 1'b1;
        req_addr  = 8'h00;
        req_wdata = 8'h11;
        req_valid = 1'b1;
        idx = 0;
        for (int c = 0; c < 60 && idx < 4; c++) begin
            if (req_ready) begin
                acc[idx] = c;
                idx++;
                tick();
                if (idx < 4) begin
                    req_addr  = 8'(idx);
                    req_wdata = 8'((idx + 1) * 8'h11);
                end else begin
                    req_valid = 1'b0;
                end
            end else begin
                tick();
            end
        end
        req_valid = 1'b0;
        check("b2b_accept_count", 32'(idx), 4);
        for (int i = 1; i < 4; i++) check("b2b_spacing", 32'(acc[i] - acc[i-1]), 4);
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        check("b2b_drained", 32'(busy), 0);
        for (int i = 0; i < 4; i++) exp_mem[8'(i)] = 8'((i + 1) * 8'h11);
        for (int i = 0; i < 4; i++) begin
            do_cmd(1'b0, 8'(i), 8'h00, 0, rd, er, wecho, lat, strobes);
            check("b2b_readback", 32'(rd), 32'(model_rd(8'(i))));
        end

        // Reset during WAIT of a read
        req_we    = 1'b0;
        req_addr  = 8'h3C;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        tick();
        req_valid = 1'b0;
        tick();
        check("mid_reset_in_wait_busy", 32'(busy), 1);
        rst_n = 1'b0;
        tick();
        check_zero_outputs("mid_reset");
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid) seen++;
            tick();
        end
        check("mid_reset_no_rsp", 32'(seen), 0);
        do_cmd(1'b0, 8'h3C, 8'h00, 0, rd, er, wecho, lat, strobes);
        check("post_reset_rdata", 32'(rd),  32'(model_rd(8'h3C)));
        check("post_reset_err",   32'(er),  0);
        check("post_reset_lat",   32'(lat), 3);

        // Randomized commands against the address->data map
        for (int i = 0; i < 30; i++) begin
            rw   = 1'($urandom_range(0, 1));
            ra   = 8'($urandom_range(0, 15));
            rdat = 8'($urandom);
            do_cmd(rw, ra, rdat, int'($urandom_range(0, 2)), rd, er, wecho, lat, strobes);
            check("rand_rsp_we",  32'(wecho), 32'(rw));
            check("rand_rsp_err", 32'(er),    0);
            check("rand_latency", 32'(lat),   3);
            if (rw) begin
                exp_mem[ra] = rdat;
                check("rand_wr_rdata", 32'(rd), 0);
            end else begin
                check("rand_rd_rdata", 32'(rd), 32'(model_rd(ra)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
